// File: rtl/branch_pkg.sv
// Shared types for the branch unit: funct3 encodings, BHT counter states and
// the saturating-counter update rule.
package branch_pkg;

   // Conditional-branch funct3 encodings; 010 and 011 are unused and illegal.
   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } funct3_e;

   // Two-bit saturating predictor counter; the MSB is the prediction.
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bhtState_e;

   // Every table entry starts weakly not-taken.
   localparam bhtState_e BHT_RESET = WNT;

   // Move one step toward ST on taken, toward SNT on not-taken, saturating.
   function automatic bhtState_e bhtNext(input bhtState_e cur, input logic taken);
      bhtState_e nxt;
      nxt = cur;
      unique case (cur)
         SNT: nxt = taken ? WNT : SNT;
         WNT: nxt = taken ? WT  : SNT;
         WT:  nxt = taken ? ST  : WNT;
         ST:  nxt = taken ? ST  : WT;
         default: nxt = BHT_RESET;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluation: resolves taken/not-taken for the six legal
// funct3 encodings and flags the two reserved ones as illegal.
module branch_cmp
   import branch_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [2:0]       funct3,
   output logic             taken,
   output logic             illegal
);

   logic isEq;
   logic isLtSigned;
   logic isLtUnsigned;

   // Shared comparators feeding every branch type.
   always_comb begin
      isEq         = (SrcA == SrcB);
      isLtSigned   = ($signed(SrcA) < $signed(SrcB));
      isLtUnsigned = (SrcA < SrcB);
   end

   // Select the condition for this funct3; reserved encodings never take.
   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         BEQ:     taken = isEq;
         BNE:     taken = ~isEq;
         BLT:     taken = isLtSigned;
         BGE:     taken = ~isLtSigned;
         BLTU:    taken = isLtUnsigned;
         BGEU:    taken = ~isLtUnsigned;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: resolves execute-stage conditional branches, flags
// mispredictions, and maintains a 2-bit-counter branch history table used for
// fetch-stage prediction, plus retired-branch and mispredict statistics.
module branch_unit
   import branch_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned BHT_ENTRIES = 16
) (
   input  logic             clk,
   input  logic             reset,
   // Fetch-stage lookup
   input  logic [WIDTH-1:0] PCF,
   output logic             PredictTakenF,
   // Execute-stage resolution
   input  logic             BranchE,
   input  logic             StallE,
   input  logic [2:0]       funct3E,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic [WIDTH-1:0] PCE,
   input  logic             PredTakenE,
   output logic             TakenE,
   output logic             MispredictE,
   output logic             IllegalBranchE,
   // Statistics
   output logic [31:0]      BranchCount,
   output logic [31:0]      MispredCount
);

   localparam int unsigned IDX_BITS = $clog2(BHT_ENTRIES);

   // Word-aligned PCs: bits [1:0] are skipped when indexing.
   logic [IDX_BITS-1:0] idxF;
   logic [IDX_BITS-1:0] idxE;

   logic      cmpTaken;
   logic      cmpIllegal;
   logic      updateEn;
   bhtState_e bhtNextState;

   bhtState_e   bht [BHT_ENTRIES];
   logic [31:0] branchCountQ;
   logic [31:0] mispredCountQ;

   // PC bits outside the index field do not affect the table.
   logic unusedPcBits;
   assign unusedPcBits = ^{PCF[WIDTH-1:IDX_BITS+2], PCF[1:0],
                           PCE[WIDTH-1:IDX_BITS+2], PCE[1:0]};

   branch_cmp #(
      .WIDTH (WIDTH)
   ) uCmp (
      .SrcA    (SrcAE),
      .SrcB    (SrcBE),
      .funct3  (funct3E),
      .taken   (cmpTaken),
      .illegal (cmpIllegal)
   );

   // Table indices for lookup and update.
   always_comb begin
      idxF = PCF[IDX_BITS+1:2];
      idxE = PCE[IDX_BITS+1:2];
   end

   // Fetch prediction reads the stored entry directly; no bypass from a
   // same-cycle update, so a new value is seen only after the edge.
   always_comb begin
      PredictTakenF = bht[idxF][1];
   end

   // Resolution outputs are gated by BranchE and a legal funct3.
   always_comb begin
      TakenE         = BranchE & ~cmpIllegal & cmpTaken;
      IllegalBranchE = BranchE & cmpIllegal;
      MispredictE    = BranchE & ~cmpIllegal & (cmpTaken ^ PredTakenE);
      updateEn       = BranchE & ~cmpIllegal & ~StallE;
   end

   // Next value of the entry being updated.
   always_comb begin
      bhtNextState = bhtNext(bht[idxE], TakenE);
   end

   // History table; reset wins over any same-cycle update.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= BHT_RESET;
         end
      end else if (updateEn) begin
         bht[idxE] <= bhtNextState;
      end
   end

   // Statistics counters, wrapping naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         branchCountQ  <= '0;
         mispredCountQ <= '0;
      end else if (updateEn) begin
         branchCountQ <= branchCountQ + 32'd1;
         if (MispredictE) begin
            mispredCountQ <= mispredCountQ + 32'd1;
         end
      end
   end

   assign BranchCount  = branchCountQ;
   assign MispredCount = mispredCountQ;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

   localparam int WIDTH       = 32;
   localparam int BHT_ENTRIES = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] PCF;
   logic             PredictTakenF;
   logic             BranchE;
   logic             StallE;
   logic [2:0]       funct3E;
   logic [WIDTH-1:0] SrcAE;
   logic [WIDTH-1:0] SrcBE;
   logic [WIDTH-1:0] PCE;
   logic             PredTakenE;
   logic             TakenE;
   logic             MispredictE;
   logic             IllegalBranchE;
   logic [31:0]      BranchCount;
   logic [31:0]      MispredCount;

   int errCount   = 0;
   int checkCount = 0;
   int expBr      = 0;
   int expMp      = 0;

   branch_unit #(
      .WIDTH       (WIDTH),
      .BHT_ENTRIES (BHT_ENTRIES)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .PCF            (PCF),
      .PredictTakenF  (PredictTakenF),
      .BranchE        (BranchE),
      .StallE         (StallE),
      .funct3E        (funct3E),
      .SrcAE          (SrcAE),
      .SrcBE          (SrcBE),
      .PCE            (PCE),
      .PredTakenE     (PredTakenE),
      .TakenE         (TakenE),
      .MispredictE    (MispredictE),
      .IllegalBranchE (IllegalBranchE),
      .BranchCount    (BranchCount),
      .MispredCount   (MispredCount)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkCounts(input string tag);
      checkVal({tag, ".brCnt"}, BranchCount, expBr);
      checkVal({tag, ".mpCnt"}, MispredCount, expMp);
   endtask

   // One qualifying update; checks resolution and the lookup at PCF before
   // and after the edge.
   task automatic doUpdate(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pce, input logic pred,
                           input logic expTaken, input logic [31:0] pcf,
                           input logic expPredBefore, input logic expPredAfter);
      PCF = pcf; BranchE = 1'b1; StallE = 1'b0; funct3E = f3;
      SrcAE = a; SrcBE = b; PCE = pce; PredTakenE = pred;
      @(negedge clk);
      checkVal({tag, ".taken"}, TakenE, expTaken);
      checkVal({tag, ".mispred"}, MispredictE, expTaken ^ pred);
      checkVal({tag, ".illegal"}, IllegalBranchE, 1'b0);
      checkVal({tag, ".predBefore"}, PredictTakenF, expPredBefore);
      tick();
      BranchE = 1'b0;
      expBr++;
      if (expTaken != pred) expMp++;
      #1;
      checkVal({tag, ".predAfter"}, PredictTakenF, expPredAfter);
      checkCounts(tag);
   endtask

   // Stalled branch: resolution is checked, nothing may update.
   task automatic doStalled(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic expTaken);
      BranchE = 1'b1; StallE = 1'b1; funct3E = f3; SrcAE = a; SrcBE = b;
      PCE = 32'h44; PCF = 32'h44; PredTakenE = 1'b0;
      @(negedge clk);
      checkVal({tag, ".taken"}, TakenE, expTaken);
      checkVal({tag, ".mispred"}, MispredictE, expTaken);
      tick();
      BranchE = 1'b0; StallE = 1'b0;
      #1;
      checkVal({tag, ".pred44"}, PredictTakenF, 1'b0);
      checkCounts(tag);
   endtask

   initial begin
      reset = 1'b1; PCF = '0; BranchE = 1'b0; StallE = 1'b0; funct3E = 3'b000;
      SrcAE = '0; SrcBE = '0; PCE = '0; PredTakenE = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      PCF = 32'h40; #1;
      checkVal("rst.pred40", PredictTakenF, 1'b0);
      checkCounts("rst");
      PCF = 32'h7C; #1;
      checkVal("rst.pred7C", PredictTakenF, 1'b0);

      // Two BEQ taken updates: WNT -> WT -> ST
      doUpdate("beq1", 3'b000, 32'd5, 32'd5, 32'h40, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
      doUpdate("beq2", 3'b000, 32'd5, 32'd5, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1);

      // Signed vs unsigned compares with StallE=1 (no updates)
      doStalled("blt",  3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1);
      doStalled("bltu", 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
      doStalled("bgeu", 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1);
      doStalled("bge",  3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);
      doStalled("bne",  3'b001, 32'd7, 32'd9, 1'b1);
      doStalled("stallBeq", 3'b000, 32'd3, 32'd3, 1'b1);

      // Reserved funct3 with BranchE=1, then with BranchE=0
      for (int k = 0; k < 2; k++) begin
         BranchE = 1'b1; StallE = 1'b0; funct3E = (k == 0) ? 3'b010 : 3'b011;
         SrcAE = 32'd5; SrcBE = 32'd5; PCE = 32'h44; PCF = 32'h44; PredTakenE = 1'b1;
         @(negedge clk);
         checkVal("illegal.flag", IllegalBranchE, 1'b1);
         checkVal("illegal.taken", TakenE, 1'b0);
         checkVal("illegal.mispred", MispredictE, 1'b0);
         tick();
         BranchE = 1'b0; #1;
         checkVal("illegal.pred44", PredictTakenF, 1'b0);
         checkCounts("illegal");
      end
      funct3E = 3'b010; BranchE = 1'b0; PredTakenE = 1'b1; #1;
      checkVal("noBranch.flag", IllegalBranchE, 1'b0);
      checkVal("noBranch.mispred", MispredictE, 1'b0);
      funct3E = 3'b000;
      checkVal("noBranch.taken", TakenE, 1'b0);

      // Reset during a qualifying update: outputs follow, update discarded
      reset = 1'b1; BranchE = 1'b1; StallE = 1'b0; funct3E = 3'b000;
      SrcAE = 32'd1; SrcBE = 32'd1; PCE = 32'h44; PCF = 32'h40; PredTakenE = 1'b0;
      @(negedge clk);
      checkVal("rstUpd.taken", TakenE, 1'b1);
      tick();
      reset = 1'b0; BranchE = 1'b0;
      expBr = 0; expMp = 0;
      #1;
      checkVal("rstUpd.pred40", PredictTakenF, 1'b0);
      checkCounts("rstUpd");
      PCF = 32'h44; #1;
      checkVal("rstUpd.pred44", PredictTakenF, 1'b0);

      // Same-index lookup/update: old value this cycle, new value next
      doUpdate("same", 3'b000, 32'd2, 32'd2, 32'h80, 1'b0, 1'b1, 32'h80, 1'b0, 1'b1);

      // Saturation on index 0: update via 0x40, look up via aliased 0x80
      doUpdate("t1", 3'b110, 32'd1, 32'd2, 32'h40, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1);
      doUpdate("t2", 3'b110, 32'd1, 32'd2, 32'h40, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1);
      doUpdate("t3", 3'b110, 32'd1, 32'd2, 32'h40, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1);
      doUpdate("t4", 3'b110, 32'd1, 32'd2, 32'h40, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1);
      doUpdate("n1", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 1'b0, 32'h80, 1'b1, 1'b1);
      doUpdate("n2", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0);
      doUpdate("n3", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 1'b0);
      doUpdate("n4", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 1'b0);
      doUpdate("n5", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0);
      // From SNT, one taken reaches only WNT; the second reaches WT
      doUpdate("r1", 3'b001, 32'd3, 32'd4, 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
      doUpdate("r2", 3'b001, 32'd3, 32'd4, 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
